// File: rtl/snes_pad_reader.sv
// SNES-style serial gamepad poller: generates latch/clock, shifts in 16 bits,
// and publishes 12 active-high buttons atomically once per frame.
module snes_pad_reader #(
  parameter int HALF_CYC    = 300,
  parameter int POLL_CYCLES = 833333,
  parameter int NUM_BUTTONS = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   pad_data,
  output logic                   pad_latch,
  output logic                   pad_clk,
  output logic [NUM_BUTTONS-1:0] buttons,
  output logic                   valid,
  output logic                   pad_err,
  output logic                   busy
);

  localparam int PW = $clog2(POLL_CYCLES);
  localparam int TW = $clog2(2 * HALF_CYC);

  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] LATCH_LAST = TW'(2 * HALF_CYC - 1);
  localparam logic [TW-1:0] HALF_LAST  = TW'(HALF_CYC - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LATCH    = 3'd1;
  localparam logic [2:0] S_CLK_LOW  = 3'd2;
  localparam logic [2:0] S_CLK_HIGH = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]    state_r;
  logic [PW-1:0] poll_cnt_r;
  logic [TW-1:0] tmr_r;
  logic [3:0]    bitcnt_r;
  logic [15:0]   shift_r;
  logic [1:0]    sync_r;
  logic          sd_s;
  logic          tick_s;

  // Trailing bits of a frame are idle-high on a real pad; any active bit there is suspect.
  function automatic logic frame_err(input logic [3:0] tail);
    return |tail;
  endfunction

  assign sd_s   = sync_r[1];
  assign tick_s = enable && (poll_cnt_r == POLL_LAST);

  // Two-flop synchronizer for the asynchronous pad data line.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], pad_data};
    end
  end

  // Frame-rate poll counter; held at zero while polling is disabled.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      poll_cnt_r <= '0;
    end else if (tick_s) begin
      poll_cnt_r <= '0;
    end else begin
      poll_cnt_r <= poll_cnt_r + 1'b1;
    end
  end

  // Frame sequencer; every output is assigned here so none is combinational.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      tmr_r     <= '0;
      bitcnt_r  <= 4'd0;
      shift_r   <= 16'h0000;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b1;
      buttons   <= '0;
      valid     <= 1'b0;
      pad_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_r)
        S_IDLE: begin
          pad_clk <= 1'b1;
          tmr_r   <= '0;
          if (tick_s) begin
            state_r   <= S_LATCH;
            pad_latch <= 1'b1;
            busy      <= 1'b1;
          end else begin
            pad_latch <= 1'b0;
            busy      <= 1'b0;
          end
        end
        S_LATCH: begin
          if (tmr_r == LATCH_LAST) begin
            tmr_r     <= '0;
            bitcnt_r  <= 4'd0;
            pad_latch <= 1'b0;
            pad_clk   <= 1'b0;
            state_r   <= S_CLK_LOW;
          end else begin
            tmr_r <= tmr_r + 1'b1;
          end
        end
        S_CLK_LOW: begin
          if (tmr_r == HALF_LAST) begin
            tmr_r             <= '0;
            shift_r[bitcnt_r] <= ~sd_s;
            pad_clk           <= 1'b1;
            state_r           <= S_CLK_HIGH;
          end else begin
            tmr_r <= tmr_r + 1'b1;
          end
        end
        S_CLK_HIGH: begin
          if (tmr_r == HALF_LAST) begin
            tmr_r <= '0;
            if (bitcnt_r == 4'd15) begin
              // Publish on entry so the DONE cycle carries the new word and strobe.
              state_r <= S_DONE;
              buttons <= shift_r[NUM_BUTTONS-1:0];
              pad_err <= frame_err(shift_r[15:12]);
              valid   <= 1'b1;
            end else begin
              bitcnt_r <= bitcnt_r + 1'b1;
              pad_clk  <= 1'b0;
              state_r  <= S_CLK_LOW;
            end
          end else begin
            tmr_r <= tmr_r + 1'b1;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r   <= S_IDLE;
          tmr_r     <= '0;
          pad_latch <= 1'b0;
          pad_clk   <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snes_pad_reader.sv
// Scoreboard bench for snes_pad_reader: behavioural pad model pushes expected
// frames at latch time, a negedge monitor pops and checks on every valid.
module tb_snes_pad_reader;

  localparam int HALF  = 4;
  localparam int POLL  = 200;
  localparam int FRAME = 34 * HALF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        pad_data = 1'b1;
  logic        pad_latch, pad_clk, valid, pad_err, busy;
  logic [11:0] buttons;

  snes_pad_reader #(.HALF_CYC(HALF), .POLL_CYCLES(POLL), .NUM_BUTTONS(12)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk), .buttons(buttons),
    .valid(valid), .pad_err(pad_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_q = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic [11:0] b;
    logic        e;
  } exp_t;
  exp_t q[$];

  // Reference: a button is pressed when its raw line reads low; any low tail bit is an error.
  function automatic exp_t model(input logic [15:0] r);
    exp_t m;
    m.b = '0;
    m.e = 1'b0;
    for (int i = 0; i < 12; i++) m.b[i] = (r[i] == 1'b0);
    for (int i = 12; i < 16; i++) if (r[i] == 1'b0) m.e = 1'b1;
    return m;
  endfunction

  // Pad model: loads on latch, advances one bit per rising pad_clk with random output skew.
  logic [15:0] raw = 16'hFFFF;
  logic [15:0] frame_raw = 16'hFFFF;
  int          idx = 0;
  initial begin
    forever begin
      @(posedge pad_latch or posedge pad_clk);
      if (pad_latch) begin
        frame_raw = raw;
        idx = 0;
        pad_data = frame_raw[0];
        q.push_back(model(raw));
      end else begin
        idx++;
        #($urandom_range(1, 9));
        pad_data = (idx < 16) ? frame_raw[idx] : 1'b1;
      end
    end
  end

  logic        prev_latch = 1'b0, prev_clk = 1'b1, prev_valid = 1'b0;
  logic [11:0] prev_buttons = '0;
  int          latch_len = 0, low_len = 0, falls = 0;
  int          latch_count = 0, valid_count = 0, latch_rise_cyc = 0;
  bit          in_frame = 1'b0;
  exp_t        e;

  always @(negedge clk) begin
    if (rst_q) begin
      in_frame = 1'b0;
      q.delete();
      falls = 0; low_len = 0; latch_len = 0;
    end else begin
      if (pad_latch && !prev_latch) begin
        latch_count++;
        latch_rise_cyc = cyc;
        in_frame = 1'b1;
        falls = 0;
        latch_len = 0;
      end
      if (pad_latch) latch_len++;
      if (!pad_latch && prev_latch) chk("latch_width", latch_len, 2 * HALF);
      if (!pad_clk && prev_clk) begin
        falls++;
        low_len = 0;
      end
      if (!pad_clk) low_len++;
      if (pad_clk && !prev_clk) chk("clk_low_width", low_len, HALF);
      if (valid) begin
        valid_count++;
        chk("valid_single", prev_valid, 1'b0);
        chk("frame_len", in_frame ? (cyc - latch_rise_cyc) : -1, FRAME);
        chk("clk_pulses", falls, 16);
        chk("busy_at_valid", busy, 1'b1);
        chk("sb_nonempty", q.size() > 0, 1'b1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("buttons", buttons, e.b);
          chk("pad_err", pad_err, e.e);
        end
        in_frame = 1'b0;
      end else begin
        chk("buttons_stable", buttons, prev_buttons);
      end
    end
    prev_latch   = pad_latch;
    prev_clk     = pad_clk;
    prev_valid   = valid;
    prev_buttons = buttons;
  end

  task automatic wait_latch(input int budget);
    int start = latch_count;
    int n = 0;
    while (latch_count == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("latch_seen", latch_count != start, 1'b1);
  endtask

  task automatic wait_valid(input int budget);
    int start = valid_count;
    int n = 0;
    while (valid_count == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("valid_seen", valid_count != start, 1'b1);
  endtask

  task automatic wait_falls(input int target, input int budget);
    int n = 0;
    while (!(falls >= target && !pad_clk) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("clk_fall_seen", (falls >= target) && !pad_clk, 1'b1);
  endtask

  int rel, vc_before, lc;

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_latch", pad_latch, 1'b0);
    chk("rst_clk", pad_clk, 1'b1);
    chk("rst_buttons", buttons, 12'h000);
    chk("rst_valid", valid, 1'b0);
    chk("rst_err", pad_err, 1'b0);
    chk("rst_busy", busy, 1'b0);

    // Idle pad: counter cycles 0..199, tick at 199, latch visible the cycle after.
    rst = 1'b0; enable = 1'b1; rel = cyc;
    wait_latch(POLL + 50);
    chk("first_latch_delay", latch_rise_cyc - rel, POLL);
    wait_valid(FRAME + 20);
    chk("idle_buttons", buttons, 12'h000);

    // B, Start, R pressed.
    raw = 16'hF7F6;
    wait_valid(POLL + 50);
    chk("buttons_809", buttons, 12'h809);

    raw = 16'hDFFF;
    wait_valid(POLL + 50);
    chk("err_bit13", pad_err, 1'b1);
    raw = 16'hF7F6;
    wait_valid(POLL + 50);
    chk("err_cleared", pad_err, 1'b0);

    // Reset during the low phase of bit 6.
    wait_latch(POLL + 50);
    wait_falls(7, FRAME);
    vc_before = valid_count;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_clk", pad_clk, 1'b1);
    chk("abort_latch", pad_latch, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_buttons", buttons, 12'h000);
    chk("abort_valid", valid, 1'b0);
    rst = 1'b0; rel = cyc;
    wait_latch(POLL + 50);
    chk("no_valid_after_abort", valid_count, vc_before);
    chk("latch_after_reset", latch_rise_cyc - rel, POLL);
    wait_valid(FRAME + 20);

    // Disable during bit 2: frame finishes, then polling stops.
    raw = 16'hFFFE;
    wait_latch(POLL + 50);
    wait_falls(3, FRAME);
    enable = 1'b0;
    wait_valid(FRAME + 20);
    chk("buttons_after_disable", buttons, 12'h001);
    lc = latch_count;
    repeat (3 * POLL) @(negedge clk);
    chk("no_latch_disabled", latch_count, lc);
    enable = 1'b1; rel = cyc;
    wait_latch(POLL + 50);
    chk("latch_after_enable", latch_rise_cyc - rel, POLL);
    wait_valid(FRAME + 20);

    for (int f = 0; f < 50; f++) begin
      raw = 16'($urandom);
      wait_valid(POLL + 50);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
